apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, APB address width.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS-phase wait cycles (used only with timeout enabled).
REQ-004 SHALL use one clock and a synchronous, active-high reset: HCLK  input  1  clock, rising edge; HRESET  input  1  synchronous active-high reset.
REQ-005 SHALL have: req_i  input  1  core request valid; gnt_o  output  1  request accepted when req_i&gnt_o; we_i  input  1  1=write, 0=read.
REQ-006 SHALL have: addr_i  input  APB_ADDR_WIDTH  byte address; wdata_i  input  APB_DATA_WIDTH  write data.
REQ-007 SHALL have: rsp_valid_o  output  1  one-cycle response pulse; rsp_rdata_o  output  APB_DATA_WIDTH  read data; rsp_err_o  output  1  error flag.
REQ-008 SHALL have APB3 initiator ports: PADDR  output  APB_ADDR_WIDTH; PWDATA  output  APB_DATA_WIDTH; PWRITE  output  1; PSEL  output  1; PENABLE  output  1; PRDATA  input  APB_DATA_WIDTH; PREADY  input  1; PSLVERR  input  1.

Function
REQ-009 SHALL implement states IDLE, SETUP, ACCESS; gnt_o = 1 only in IDLE; one transaction outstanding.
REQ-010 SHALL, on req_i&gnt_o with addr_i[1:0]==0, register addr/wdata/we into PADDR/PWDATA/PWRITE and go to SETUP.
REQ-011 SHALL drive PSEL=1, PENABLE=0 in SETUP, then go to ACCESS unconditionally.
REQ-012 SHALL drive PSEL=1, PENABLE=1 in ACCESS; PADDR/PWDATA/PWRITE stable from SETUP until exit from ACCESS.
REQ-013 SHALL remain in ACCESS while PREADY=0; on PREADY=1 go to IDLE, registering rsp_err_o=PSLVERR and rsp_rdata_o=PRDATA on reads (0 on writes).
REQ-014 SHALL assert rsp_valid_o for exactly one cycle, the cycle after completion; zero-wait-state latency accept->rsp_valid_o = 3 cycles.
REQ-015 SHALL allow back-to-back: a new request may be accepted in the same IDLE cycle that rsp_valid_o is high.
REQ-016 SHALL, for a misaligned request (addr_i[1:0]!=0), accept it, issue no APB cycle, remain in IDLE, and pulse rsp_valid_o with rsp_err_o=1, rsp_rdata_o=0 on the next cycle.
REQ-017 SHALL hold PSEL=0, PENABLE=0 in IDLE; rsp_rdata_o/rsp_err_o hold their value until the next response.

Reset
REQ-018 SHALL, on HRESET=1 at a rising edge, enter IDLE with PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, timeout counter=0.
REQ-019 SHALL abort any in-flight transfer on reset without producing a response.

Configuration
REQ-020 SHALL compile an ACCESS-phase timeout only when macro APB_MASTER_TIMEOUT_EN is defined.
REQ-021 With APB_MASTER_TIMEOUT_EN: counter clears on entering ACCESS, increments each ACCESS cycle with PREADY=0; when it reaches TIMEOUT_CYCLES with PREADY still 0, the block SHALL go to IDLE (PSEL/PENABLE low next cycle) and respond with rsp_err_o=1, rsp_rdata_o=0; PREADY=1 in that same cycle takes priority (normal completion).
REQ-022 Without APB_MASTER_TIMEOUT_EN: no counter logic; ACCESS waits indefinitely for PREADY.

Structure
REQ-023 SHALL place the state enum (IDLE/SETUP/ACCESS) and default width constants in shared package apb_master_pkg.
REQ-024 SHALL place the timeout counter in sub-module apb_master_timeout, instantiated only under APB_MASTER_TIMEOUT_EN.

Verification
REQ-025 Write addr 0x010 data 0xDEADBEEF, PREADY=1 -> SETUP then ACCESS with PADDR=0x010, PWRITE=1; rsp_valid_o 3 cycles after accept, rsp_err_o=0.
REQ-026 Read addr 0x004, PREADY low 4 ACCESS cycles, PRDATA=0x12345678 -> PENABLE high 5 cycles, rsp_rdata_o=0x12345678, signals stable throughout.
REQ-027 Read with PSLVERR=1 on completion -> rsp_err_o=1; back-to-back request accepted in rsp_valid_o cycle, its SETUP follows next cycle.
REQ-028 Request addr 0x006 -> no PSEL, rsp_valid_o next cycle, rsp_err_o=1, rsp_rdata_o=0.
REQ-029 With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8, PREADY held 0 -> exit after 8 wait cycles, rsp_err_o=1; PREADY=1 on the 8th cycle -> normal response.
REQ-030 HRESET asserted during ACCESS -> next cycle PSEL=0, PENABLE=0, state IDLE, no rsp_valid_o.

Source files
------------

// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB3 initiator.
// Optional ACCESS-phase timeout is compiled in with APB_MASTER_TIMEOUT_EN.
package apb_master_pkg;

  localparam int APB_ADDR_WIDTH_DEFAULT = 12;
  localparam int APB_DATA_WIDTH_DEFAULT = 32;
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/apb_master_timeout.sv
// ACCESS-phase wait counter; only instantiated when APB_MASTER_TIMEOUT_EN is defined.
// expired_o fires on the TIMEOUT_CYCLES-th consecutive ACCESS cycle with PREADY low.
module apb_master_timeout
  import apb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic start_i,
  input  logic active_i,
  input  logic pready_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_q, count_d;

  // count_q holds the number of wait cycles already seen before the current one
  always_comb begin
    count_d = count_q;
    if (start_i) begin
      count_d = '0;
    end else if (active_i && !pready_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = active_i && !pready_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB3 initiator bridging a simple req/gnt core port.
// Define APB_MASTER_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT_CYCLES wait cycles.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = APB_ADDR_WIDTH_DEFAULT,
  parameter int APB_DATA_WIDTH = APB_DATA_WIDTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      rsp_valid_o,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [APB_DATA_WIDTH-1:0] PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  apb_state_e                state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      timeout_expired;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_master_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .start_i   (state_q == SETUP),
    .active_i  (state_q == ACCESS),
    .pready_i  (PREADY),
    .expired_o (timeout_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_expired    = 1'b0;
`endif

  // Misaligned requests are answered from IDLE without touching the bus
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          if (is_word_aligned(addr_i[1:0])) begin
            paddr_d  = addr_i;
            pwdata_d = wdata_i;
            pwrite_d = we_i;
            state_d  = SETUP;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
        end else if (timeout_expired) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign gnt_o       = (state_q == IDLE);
  assign PSEL        = (state_q != IDLE);
  assign PENABLE     = (state_q == ACCESS);
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PWRITE      = pwrite_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Randomized self-checking bench for apb_master against a transaction-level model.
// Timeout scenarios are exercised only when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          req_i, gnt_o, we_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic          rsp_valid_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PWRITE, PSEL, PENABLE;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR;

  int n_vec = 0;
  int n_err = 0;

  always #5 HCLK = ~HCLK;

  apb_master #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Transaction-level expectation: cycles from accept to response and the response contents
  function automatic void model(input logic we, input logic [AW-1:0] addr, input int waits,
                                input logic slverr, input logic [DW-1:0] prdata,
                                output int e_lat, output int e_setup, output int e_access,
                                output logic [DW-1:0] e_rdata, output logic e_err);
    if (addr % 4 != 0) begin
      e_lat = 1; e_setup = 0; e_access = 0; e_rdata = '0; e_err = 1'b1;
    end else if (TIMEOUT_EN && waits >= TO) begin
      e_lat = TO + 2; e_setup = 1; e_access = TO; e_rdata = '0; e_err = 1'b1;
    end else begin
      e_lat = waits + 3; e_setup = 1; e_access = waits + 1;
      e_rdata = we ? '0 : prdata; e_err = slverr;
    end
  endfunction

  // Issues one request at the current negedge and plays a slave that raises PREADY after
  // 'waits' ACCESS cycles; returns at the negedge where rsp_valid_o is seen (lat=-1 if never).
  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int waits, input logic slverr, input logic [DW-1:0] prdata,
                         output int lat, output int n_setup, output int n_access,
                         output bit stable, output bit gnt_seen,
                         output logic [DW-1:0] r_rdata, output logic r_err);
    lat = -1; n_setup = 0; n_access = 0; stable = 1'b1; gnt_seen = gnt_o;
    r_rdata = 'x; r_err = 1'bx;
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; PREADY = 1'b0;
    for (int c = 1; c <= waits + TO + 20; c++) begin
      @(negedge HCLK);
      req_i = 1'b0; we_i = 1'($urandom); addr_i = AW'($urandom); wdata_i = $urandom;
      if (PSEL) begin
        if (PADDR !== addr || PWRITE !== we || PWDATA !== wdata) stable = 1'b0;
        if (PENABLE) n_access++;
        else n_setup++;
      end else if (PENABLE) begin
        stable = 1'b0;
      end
      if (rsp_valid_o) begin
        lat = c; r_rdata = rsp_rdata_o; r_err = rsp_err_o; PREADY = 1'b0;
        break;
      end
      PREADY  = PSEL && PENABLE && (n_access == waits + 1);
      PSLVERR = PREADY ? slverr : 1'($urandom);
      PRDATA  = PREADY ? prdata : $urandom;
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1; req_i = 1'b0; we_i = 1'b1; addr_i = 12'h3F0; wdata_i = '1;
    PRDATA = '1; PREADY = 1'b1; PSLVERR = 1'b1;
    repeat (3) @(negedge HCLK);
    n_vec++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid_o, rsp_err_o, gnt_o} !== 6'b000001) begin
      n_err++;
      $display("[TB] FAIL reset_ctrl got %b exp 000001",
               {PSEL, PENABLE, PWRITE, rsp_valid_o, rsp_err_o, gnt_o});
    end
    n_vec++;
    if (PADDR !== '0 || PWDATA !== '0 || rsp_rdata_o !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_data got paddr=%h pwdata=%h rdata=%h exp all 0",
               PADDR, PWDATA, rsp_rdata_o);
    end
    HRESET = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic test_write_basic();
    int lat, ns, na; bit st, g; logic [DW-1:0] rd; logic er;
    run_txn(1'b1, 12'h010, 32'hDEADBEEF, 0, 1'b0, 32'hA5A5A5A5, lat, ns, na, st, g, rd, er);
    n_vec++;
    if (lat !== 3 || ns !== 1 || na !== 1) begin
      n_err++;
      $display("[TB] FAIL wr_timing got lat=%0d setup=%0d access=%0d exp 3/1/1", lat, ns, na);
    end
    n_vec++;
    if (st !== 1'b1 || g !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL wr_bus got stable=%0d gnt=%0d exp 1/1", st, g);
    end
    n_vec++;
    if (er !== 1'b0 || rd !== '0) begin
      n_err++;
      $display("[TB] FAIL wr_rsp got err=%0d rdata=%h exp 0/00000000", er, rd);
    end
  endtask

  task automatic test_wait_read();
    int lat, ns, na; bit st, g; logic [DW-1:0] rd; logic er;
    run_txn(1'b0, 12'h004, 32'h0BAD0BAD, 4, 1'b0, 32'h12345678, lat, ns, na, st, g, rd, er);
    n_vec++;
    if (na !== 5 || lat !== 7 || st !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL rd_wait got penable_cycles=%0d lat=%0d stable=%0d exp 5/7/1", na, lat, st);
    end
    n_vec++;
    if (rd !== 32'h12345678 || er !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL rd_data got rdata=%h err=%0d exp 12345678/0", rd, er);
    end
  endtask

  task automatic test_misaligned();
    int lat, ns, na; bit st, g; logic [DW-1:0] rd; logic er;
    run_txn(1'b0, 12'h006, 32'h0, 0, 1'b0, 32'hFFFFFFFF, lat, ns, na, st, g, rd, er);
    n_vec++;
    if (lat !== 1 || ns !== 0 || na !== 0) begin
      n_err++;
      $display("[TB] FAIL misalign_bus got lat=%0d setup=%0d access=%0d exp 1/0/0", lat, ns, na);
    end
    n_vec++;
    if (er !== 1'b1 || rd !== '0) begin
      n_err++;
      $display("[TB] FAIL misalign_rsp got err=%0d rdata=%h exp 1/00000000", er, rd);
    end
  endtask

  task automatic test_back_to_back();
    int lat, ns, na; bit st, g; logic [DW-1:0] rd; logic er;
    run_txn(1'b0, 12'h100, 32'h0, 1, 1'b1, 32'hCAFEF00D, lat, ns, na, st, g, rd, er);
    n_vec++;
    if (er !== 1'b1 || rd !== 32'hCAFEF00D || lat !== 4) begin
      n_err++;
      $display("[TB] FAIL slverr_rsp got err=%0d rdata=%h lat=%0d exp 1/cafef00d/4", er, rd, lat);
    end
    run_txn(1'b1, 12'h104, 32'h5555AAAA, 0, 1'b0, 32'h0, lat, ns, na, st, g, rd, er);
    n_vec++;
    if (g !== 1'b1 || lat !== 3 || ns !== 1 || st !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL b2b got gnt=%0d lat=%0d setup=%0d stable=%0d exp 1/3/1/1", g, lat, ns, st);
    end
  endtask

  task automatic test_hold();
    int lat, ns, na; bit st, g; logic [DW-1:0] rd; logic er;
    logic [DW-1:0] pd;
    pd = $urandom | 32'h1;
    run_txn(1'b0, 12'h0F0, 32'h0, 2, 1'b0, pd, lat, ns, na, st, g, rd, er);
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      n_vec++;
      if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== pd || rsp_err_o !== 1'b0 || PSEL !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL hold got valid=%0d rdata=%h err=%0d psel=%0d exp 0/%h/0/0",
                 rsp_valid_o, rsp_rdata_o, rsp_err_o, PSEL, pd);
      end
    end
  endtask

  task automatic test_reset_during_access();
    bit reached = 1'b0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 12'h020; PREADY = 1'b0;
    for (int c = 0; c < 6 && !reached; c++) begin
      @(negedge HCLK);
      req_i = 1'b0;
      if (PSEL && PENABLE) reached = 1'b1;
    end
    n_vec++;
    if (!reached) begin
      n_err++;
      $display("[TB] FAIL abort_reach got access=0 exp 1");
    end
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0; PREADY = 1'b1; PRDATA = 32'h77777777;
    n_vec++;
    if ({PSEL, PENABLE, rsp_valid_o, gnt_o} !== 4'b0001 || PADDR !== '0) begin
      n_err++;
      $display("[TB] FAIL abort got psel/pen/valid/gnt=%b paddr=%h exp 0001/000",
               {PSEL, PENABLE, rsp_valid_o, gnt_o}, PADDR);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      n_vec++;
      if (rsp_valid_o !== 1'b0 || PSEL !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL abort_quiet got valid=%0d psel=%0d exp 0/0", rsp_valid_o, PSEL);
      end
    end
    PREADY = 1'b0;
  endtask

  task automatic test_timeout();
    int lat, ns, na; bit st, g; logic [DW-1:0] rd; logic er;
    run_txn(1'b0, 12'h040, 32'h0, TO, 1'b0, 32'h13579BDF, lat, ns, na, st, g, rd, er);
    n_vec++;
    if (na !== TO || lat !== TO + 2 || er !== 1'b1 || rd !== '0) begin
      n_err++;
      $display("[TB] FAIL timeout got access=%0d lat=%0d err=%0d rdata=%h exp %0d/%0d/1/0",
               na, lat, er, rd, TO, TO + 2);
    end
    run_txn(1'b0, 12'h044, 32'h0, TO - 1, 1'b0, 32'h2468ACE0, lat, ns, na, st, g, rd, er);
    n_vec++;
    if (na !== TO || lat !== TO + 2 || er !== 1'b0 || rd !== 32'h2468ACE0) begin
      n_err++;
      $display("[TB] FAIL timeout_edge got access=%0d lat=%0d err=%0d rdata=%h exp %0d/%0d/0/2468ace0",
               na, lat, er, rd, TO, TO + 2);
    end
  endtask

  task automatic test_random();
    int lat, ns, na, e_lat, e_setup, e_access, waits, gap;
    bit st, g; logic [DW-1:0] rd, e_rdata, wd, pd; logic er, e_err, we, sl;
    logic [AW-1:0] addr;
    for (int t = 0; t < 60; t++) begin
      we = 1'($urandom); wd = $urandom; pd = $urandom; sl = 1'($urandom);
      addr = AW'($urandom);
      if ($urandom_range(0, 3) != 0) addr = addr & ~AW'(3);
      waits = TIMEOUT_EN ? $urandom_range(0, TO + 3) : $urandom_range(0, 6);
      model(we, addr, waits, sl, pd, e_lat, e_setup, e_access, e_rdata, e_err);
      run_txn(we, addr, wd, waits, sl, pd, lat, ns, na, st, g, rd, er);
      n_vec++;
      if (lat !== e_lat || ns !== e_setup || na !== e_access || st !== 1'b1 || g !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL rand_bus[%0d] got lat=%0d setup=%0d access=%0d stable=%0d gnt=%0d exp %0d/%0d/%0d/1/1",
                 t, lat, ns, na, st, g, e_lat, e_setup, e_access);
      end
      n_vec++;
      if (rd !== e_rdata || er !== e_err) begin
        n_err++;
        $display("[TB] FAIL rand_rsp[%0d] got rdata=%h err=%0d exp %h/%0d", t, rd, er, e_rdata, e_err);
      end
      if (lat < 0) begin
        HRESET = 1'b1; @(negedge HCLK); HRESET = 1'b0; PREADY = 1'b0;
      end
      gap = $urandom_range(0, 2);
      for (int i = 0; i < gap; i++) begin
        @(negedge HCLK);
        n_vec++;
        if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== e_rdata || rsp_err_o !== e_err) begin
          n_err++;
          $display("[TB] FAIL rand_gap[%0d] got valid=%0d rdata=%h err=%0d exp 0/%h/%0d",
                   t, rsp_valid_o, rsp_rdata_o, rsp_err_o, e_rdata, e_err);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_wait_read();
    test_misaligned();
    test_back_to_back();
    test_hold();
    test_reset_during_access();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
